bellatrix_wb_arbiter: RTL

- Two-master, one-slave Wishbone B4 arbiter. Lets the core's instruction port (m0) and data port (m1) share a single memory or peripheral slave port.
- Used in single-port memory configurations of the testbench and SoC, placed between bellatrix_core and the ram/bus.
- Provides registered grant, burst locking on cyc, selectable priority, and a bus-timeout watchdog that converts a hung slave into err.

---
 rtl/bellatrix_pkg.sv | 27 ++
 rtl/bellatrix_wb_timeout.sv | 53 +++++
 rtl/bellatrix_wb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bellatrix_pkg.sv
// Shared types and constants for the bellatrix Wishbone fabric: arbiter
// ownership states, Wishbone cycle-type codes and the tie-break helper.
package bellatrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Winner when both masters request in the same idle cycle. last_m1 is
    // set when master 1 was the most recent owner to release the bus.
    function automatic arb_state_e arb_tie_winner(input logic rr_mode, input logic last_m1);
        arb_state_e win;
        if (rr_mode && last_m1) begin
            win = ST_OWN0;
        end else begin
            win = ST_OWN1;
        end
        return win;
    endfunction

endpackage

// File: rtl/bellatrix_wb_timeout.sv
// Bus watchdog: counts stalled strobe cycles and flags a forced error when
// the slave has left the owner waiting TIMEOUT cycles. TIMEOUT=0 disables it.
module bellatrix_wb_timeout
    import bellatrix_pkg::*;
#(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic err,
    input  logic grant_change,
    output logic to_fire
);

    localparam logic                EN       = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);
    localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0] TO_ZERO  = {TO_WIDTH{1'b0}};
    localparam logic [TO_WIDTH-1:0] TO_MAX   = {TO_WIDTH{1'b1}};

    logic [TO_WIDTH-1:0] count_q;
    logic [TO_WIDTH-1:0] count_d;
    logic                fire_s;

    // Fire only while a strobe is actually pending, so a grant change or a
    // dropped stb can never produce a stray error.
    always_comb begin
        fire_s  = EN & stb & (count_q == TO_LIMIT);
        count_d = count_q;
        if (!EN || fire_s || ack || err || !stb || grant_change) begin
            count_d = TO_ZERO;
        end else if (count_q != TO_MAX) begin
            count_d = count_q + TO_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= TO_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign to_fire = fire_s;

endmodule

// File: rtl/bellatrix_wb_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter with cyc-locked grant, fixed or
// round-robin tie-breaking and a watchdog that turns a hung slave into err.
module bellatrix_wb_arbiter
    import bellatrix_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 255,
    parameter int TO_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_dat_w,
    input  logic [3:0]            m0_sel,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [2:0]            m0_cti,
    input  logic [1:0]            m0_bte,
    output logic [31:0]           m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_dat_w,
    input  logic [3:0]            m1_sel,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [2:0]            m1_cti,
    input  logic [1:0]            m1_bte,
    output logic [31:0]           m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_dat_w,
    output logic [3:0]            s_sel,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [2:0]            s_cti,
    output logic [1:0]            s_bte,
    input  logic [31:0]           s_dat_r,
    input  logic                  s_ack,
    input  logic                  s_err,
    output logic [1:0]            grant
);

    localparam logic RR_MODE = (PRIORITY_MODE != 0);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;

    logic       own0_s;
    logic       own1_s;
    logic       req_stb_s;
    logic       grant_change_s;
    logic       to_fire_s;

    // Ownership FSM: grant is locked for the owner's whole cyc and the bus
    // always passes through IDLE before changing hands.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_d = arb_tie_winner(RR_MODE, last_q);
                end else if (m1_cyc) begin
                    state_d = ST_OWN1;
                end else if (m0_cyc) begin
                    state_d = ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end else begin
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end else begin
                    state_d = ST_OWN1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = 1'b0;
            end
        endcase
    end

    // Ownership and last-owner registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign own0_s         = (state_q == ST_OWN0);
    assign own1_s         = (state_q == ST_OWN1);
    assign grant_change_s = (state_d != state_q);
    assign grant          = state_q;

    // Forward the owner's request to the slave; an idle bus drives zeros.
    always_comb begin
        s_addr    = {ADDR_WIDTH{1'b0}};
        s_dat_w   = 32'h0000_0000;
        s_sel     = 4'b0000;
        s_cyc     = 1'b0;
        req_stb_s = 1'b0;
        s_we      = 1'b0;
        s_cti     = CTI_CLASSIC;
        s_bte     = 2'b00;
        case (state_q)
            ST_OWN0: begin
                s_addr    = m0_addr;
                s_dat_w   = m0_dat_w;
                s_sel     = m0_sel;
                s_cyc     = m0_cyc;
                req_stb_s = m0_stb;
                s_we      = m0_we;
                s_cti     = m0_cti;
                s_bte     = m0_bte;
            end
            ST_OWN1: begin
                s_addr    = m1_addr;
                s_dat_w   = m1_dat_w;
                s_sel     = m1_sel;
                s_cyc     = m1_cyc;
                req_stb_s = m1_stb;
                s_we      = m1_we;
                s_cti     = m1_cti;
                s_bte     = m1_bte;
            end
            default: begin
                s_cyc     = 1'b0;
                req_stb_s = 1'b0;
            end
        endcase
    end

    // The watchdog sees the unmasked strobe so s_ack never feeds an s_* output.
    bellatrix_wb_timeout #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .stb          (req_stb_s),
        .ack          (s_ack),
        .err          (s_err),
        .grant_change (grant_change_s),
        .to_fire      (to_fire_s)
    );

    assign s_stb = req_stb_s & ~to_fire_s;

    // A real ack coinciding with the watchdog firing beats the forced error.
    assign m0_ack   = s_ack & own0_s;
    assign m1_ack   = s_ack & own1_s;
    assign m0_err   = own0_s & (s_err | (to_fire_s & ~s_ack));
    assign m1_err   = own1_s & (s_err | (to_fire_s & ~s_ack));
    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

endmodule
